// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: collects a host byte stream into
// little-endian 32-bit words and writes them from address 0 upward.
module imem_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_data_in,
    output logic                  mem_rw,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];
    // Counter only needs to reach TIMEOUT-1; the following idle cycle aborts.
    localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int              TMO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0]   TMO_LAST   = TMO_LAST_I[TW-1:0];

    logic [2:0]            state;
    logic [ADDR_WIDTH:0]   n_words;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [1:0]            byte_idx;
    logic [31:0]           asm_word;
    logic [31:0]           wr_data;
    logic [TW-1:0]         tmo_cnt;
    logic [ADDR_WIDTH:0]   n_clamped;
    logic [ADDR_WIDTH:0]   word_idx_nxt;
    logic                  xfer;

    assign n_clamped    = (word_count > DEPTH_W) ? DEPTH_W : word_count;
    assign word_idx_nxt = word_idx + 1'b1;
    assign xfer         = byte_valid & byte_ready;

    assign byte_ready  = (state == S_COLLECT);
    assign busy        = (state == S_COLLECT) || (state == S_WRITE);
    assign cpu_hold    = busy;
    assign done        = (state == S_DONE);
    assign err         = (state == S_ERROR);
    assign mem_rw      = (state != S_WRITE);
    assign mem_address = busy ? word_idx[ADDR_WIDTH-1:0] : '0;
    assign mem_data_in = wr_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            n_words  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            asm_word <= '0;
            wr_data  <= '0;
            tmo_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_words  <= n_clamped;
                        word_idx <= '0;
                        byte_idx <= '0;
                        tmo_cnt  <= '0;
                        state    <= (n_clamped == '0) ? S_DONE : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (xfer) begin
                        asm_word[{byte_idx, 3'b000} +: 8] <= byte_data;
                        byte_idx <= byte_idx + 1'b1;
                        tmo_cnt  <= '0;
                        if (byte_idx == 2'd3) begin
                            // Publish the finished word directly so it is stable for the WRITE cycle
                            wr_data <= {byte_data, asm_word[23:0]};
                            state   <= S_WRITE;
                        end
                    end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
                        asm_word <= '0;
                        state    <= S_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx_nxt;
                    byte_idx <= '0;
                    tmo_cnt  <= '0;
                    state    <= (word_idx_nxt == n_words) ? S_DONE : S_COLLECT;
                end
                S_DONE:  state <= S_IDLE;
                S_ERROR: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes/events are queued by the
// stimulus and consumed by an independent negedge monitor.
module tb_imem_loader;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   word_count;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_data_in;
    logic          mem_rw;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic          err;

    imem_loader #(.ADDR_WIDTH(AW), .DEPTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_rw(mem_rw),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    int xfers   = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];
    int            exp_ev_q[$];   // 1 = done, 2 = err

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares every memory write and every done/err pulse against the queues.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (byte_valid && byte_ready) xfers++;
            if (busy !== cpu_hold) chk("cpu_hold_eq_busy", {31'd0, cpu_hold}, {31'd0, busy});
            if (mem_rw === 1'b0) begin
                if (byte_ready) chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_write_addr", {27'd0, mem_address}, 32'hFFFF_FFFF);
                end else begin
                    chk("write_addr", {27'd0, mem_address}, {27'd0, exp_addr_q.pop_front()});
                    chk("write_data", mem_data_in, exp_data_q.pop_front());
                end
            end
            if (done === 1'b1 || err === 1'b1) begin
                if (exp_ev_q.size() == 0) chk("unexpected_event", {30'd0, err, done}, 32'd0);
                else chk("event_kind", {30'd0, err, done}, (exp_ev_q.pop_front() == 1) ? 32'd1 : 32'd2);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_load(input int wc);
        word_count = wc[AW:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_data  = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                tick();
                byte_valid = 1'b0;
                return;
            end
        end
        byte_valid = 1'b0;
        chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    // Word i of a load built from bytes base, base+1, ... is {b3,b2,b1,b0}.
    function automatic logic [31:0] word_of(input int base, input int i);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(base + 4*i);
        b1 = 8'(base + 4*i + 1);
        b2 = 8'(base + 4*i + 2);
        b3 = 8'(base + 4*i + 3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic run_load(input int wc, input int nbytes, input int base,
                            input int gapmax, input int nwrites);
        for (int i = 0; i < nwrites; i++) begin
            exp_addr_q.push_back(AW'(i));
            exp_data_q.push_back(word_of(base, i));
        end
        start_load(wc);
        for (int k = 0; k < nbytes; k++)
            send_byte(8'(base + k), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    endtask

    task automatic wait_event(input string name);
        for (int i = 0; i < 200; i++) begin
            if (done || err) begin
                tick();
                return;
            end
            tick();
        end
        chk(name, 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        reset = 1'b0; start = 1'b0; word_count = '0; byte_data = '0; byte_valid = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {18'd0, mem_rw, byte_ready, busy, cpu_hold, done, err, 3'd0, mem_address},
            {18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0});
        chk("reset_data", mem_data_in, 32'd0);
        reset = 1'b1;
        tick();

        // Single word, back-to-back bytes
        exp_addr_q.push_back(0); exp_data_q.push_back(32'h0010_0513); exp_ev_q.push_back(1);
        start_load(1);
        send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        chk("t1_write_cycle", {mem_rw, 26'd0, mem_address}, {1'b0, 26'd0, 5'd0});
        chk("t1_write_data", mem_data_in, 32'h0010_0513);
        tick();
        chk("t1_done_pulse", {29'd0, done, busy, cpu_hold}, 32'b100);
        tick();
        chk("t1_after_done", {29'd0, done, busy, mem_rw}, 32'b001);
        chk("t1_data_held", mem_data_in, 32'h0010_0513);

        // Two words with random valid gaps
        xfers = 0;
        exp_ev_q.push_back(1);
        run_load(2, 8, 8'hA0, 5, 2);
        wait_event("t2_done_wait");
        chk("t2_xfers", xfers, 8);

        // Full depth with clamp (40 -> 32)
        xfers = 0;
        exp_ev_q.push_back(1);
        run_load(40, 128, 0, 0, 32);
        chk("t3_last_write_addr", {31'd0, mem_rw}, 32'd0);
        chk("t3_last_addr", {27'd0, mem_address}, 32'd31);
        wait_event("t3_done_wait");
        chk("t3_xfers", xfers, 128);
        chk("t3_queue_empty", exp_addr_q.size(), 0);

        // Timeout after 6 bytes
        exp_ev_q.push_back(2);
        run_load(2, 6, 8'h40, 0, 1);
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (err) begin c = i; break; end
        end
        chk("t4_err_latency", c, 16);
        chk("t4_busy_at_err", {30'd0, busy, cpu_hold}, 32'd0);
        tick();
        chk("t4_idle_after_err", {29'd0, err, byte_ready, busy}, 32'd0);

        // Zero count: done right after the accept edge, no write
        exp_ev_q.push_back(1);
        start_load(0);
        chk("t5_zero_done", {30'd0, done, mem_rw}, 32'b11);
        tick();

        // Start pulse during an active load is ignored
        exp_addr_q.push_back(0); exp_data_q.push_back(32'hDDCC_BBAA); exp_ev_q.push_back(1);
        start_load(1);
        send_byte(8'hAA, 0);
        start = 1'b1; word_count = 6'd5;
        send_byte(8'hBB, 0);
        start = 1'b0;
        send_byte(8'hCC, 1); send_byte(8'hDD, 0);
        wait_event("t5_done_wait");
        repeat (3) tick();
        chk("t5_no_retrigger", {30'd0, busy, mem_rw}, 32'b01);

        // Reset after 2 bytes of word 3
        run_load(5, 14, 8'h60, 0, 3);
        reset = 1'b0;
        tick();
        chk("t6_reset_outputs", {26'd0, mem_rw, byte_ready, busy, cpu_hold, done, err},
            {26'd0, 6'b100000});
        chk("t6_reset_addr_data", {27'd0, mem_address} | mem_data_in, 32'd0);
        reset = 1'b1;
        tick();
        exp_ev_q.push_back(1);
        run_load(1, 4, 8'h70, 0, 1);
        wait_event("t6_done_wait");

        repeat (3) tick();
        chk("final_write_queue", exp_addr_q.size(), 0);
        chk("final_event_queue", exp_ev_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
